// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplex scanner and the charlieplexer it drives:
// LED-count/index-width helpers and the scanner state encoding.
package charlieplex_pkg;

  // Scanner states: park, inter-LED blanking gap, LED lit/dwell slot.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } scan_state_e;

  // Number of LEDs a charlieplexed array of 'pincount' pins can address.
  function automatic int led_count(input int pincount);
    return pincount * (pincount - 1);
  endfunction

  // Width of an LED index for 'pincount' pins (at least one bit).
  function automatic int index_bits(input int pincount);
    int n;
    n = led_count(pincount);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a down-counter that must hold the larger of the two slot lengths.
  function automatic int count_bits(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/charlieplex_next_lit.sv
// Combinational priority finder: lowest set bit of i_frame strictly above
// i_index, or the lowest set bit overall when i_from_start is high.
module charlieplex_next_lit
  import charlieplex_pkg::*;
#(
  parameter int LEDCOUNT  = 12,
  parameter int INDEXBITS = 4
) (
  input  logic [LEDCOUNT-1:0]  i_frame,
  input  logic [INDEXBITS-1:0] i_index,
  input  logic                 i_from_start,
  output logic [INDEXBITS-1:0] o_next,
  output logic                 o_found
);

  // Scan downwards so the last hit written is the lowest qualifying index.
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    for (int i = LEDCOUNT - 1; i >= 0; i--) begin
      if (i_frame[i] && (i_from_start || (INDEXBITS'(i) > i_index))) begin
        o_next  = INDEXBITS'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/charlieplex_scanner.sv
// Time-multiplexes a one-bit-per-LED bitmap onto a charlieplexer. Frames are
// accepted into a shadow buffer and swapped into the active frame only at
// scan wrap, so a scan always shows a single complete frame. Every LED slot
// is preceded by a blanking gap so led_index never moves while lit.
//
// Frame handshake: a transfer happens on any clk edge where frame_valid and
// frame_ready are both 1. frame_ready is a registered copy of "shadow empty",
// so at most one frame is taken per shadow drain; frame_data must be held
// stable while frame_valid is 1 and frame_valid must not depend on
// frame_ready.
module charlieplex_scanner
  import charlieplex_pkg::*;
#(
  parameter int  PINCOUNT     = 4,
  parameter int  DWELL_CYCLES = 1000,
  parameter int  BLANK_CYCLES = 2,
  parameter int  SKIP_DARK    = 1,
  localparam int LEDCOUNT     = led_count(PINCOUNT),
  localparam int INDEXBITS    = index_bits(PINCOUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [LEDCOUNT-1:0]  frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [INDEXBITS-1:0] led_index,
  output logic                 led_enable,
  output logic                 frame_done,
  output scan_state_e          dbg_state
);

  localparam int                  CNTBITS    = count_bits(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNTBITS-1:0]  BLANK_LOAD = CNTBITS'(BLANK_CYCLES - 1);
  localparam logic [CNTBITS-1:0]  DWELL_LOAD = CNTBITS'(DWELL_CYCLES - 1);
  localparam logic [CNTBITS-1:0]  CNT_ONE    = CNTBITS'(1);
  // With SKIP_DARK=0 every LED gets a slot, so the finders treat all bits as lit.
  localparam logic [LEDCOUNT-1:0] VISIT_ALL  = {LEDCOUNT{(SKIP_DARK == 0)}};

  // Registered state
  scan_state_e          r_state;
  logic [CNTBITS-1:0]   r_cnt;
  logic [INDEXBITS-1:0] r_led_index;
  logic                 r_led_enable;
  logic                 r_frame_done;
  logic [LEDCOUNT-1:0]  r_active;
  logic [LEDCOUNT-1:0]  r_shadow;
  logic                 r_shadow_full;
  logic                 r_frame_ready;
  logic                 r_have_frame;

  // Next-state and helper wires
  scan_state_e          w_state_nxt;
  logic [CNTBITS-1:0]   w_cnt_nxt;
  logic [INDEXBITS-1:0] w_index_nxt;
  logic                 w_enable_nxt;
  logic                 w_done_nxt;
  logic                 w_swap;
  logic                 w_accept;
  logic                 w_shadow_full_nxt;
  logic [LEDCOUNT-1:0]  w_first_frame;
  logic [LEDCOUNT-1:0]  w_cur_mask;
  logic [LEDCOUNT-1:0]  w_first_mask;
  logic [INDEXBITS-1:0] w_next_idx;
  logic                 w_next_found;
  logic [INDEXBITS-1:0] w_first_idx;
  logic                 w_first_found;
  logic [INDEXBITS-1:0] w_first_pos;

  assign w_accept      = frame_valid && r_frame_ready;
  // Whenever a scan (re)starts, the frame it will show is the shadow if one is waiting.
  assign w_first_frame = r_shadow_full ? r_shadow : r_active;
  assign w_cur_mask    = r_active | VISIT_ALL;
  assign w_first_mask  = w_first_frame | VISIT_ALL;
  // An all-dark frame parks on index 0.
  assign w_first_pos   = w_first_found ? w_first_idx : '0;
  // A swap consumes the old shadow; a same-cycle accept refills it.
  assign w_shadow_full_nxt = w_accept ? 1'b1 : (w_swap ? 1'b0 : r_shadow_full);

  charlieplex_next_lit #(
    .LEDCOUNT  (LEDCOUNT),
    .INDEXBITS (INDEXBITS)
  ) u_next (
    .i_frame      (w_cur_mask),
    .i_index      (r_led_index),
    .i_from_start (1'b0),
    .o_next       (w_next_idx),
    .o_found      (w_next_found)
  );

  charlieplex_next_lit #(
    .LEDCOUNT  (LEDCOUNT),
    .INDEXBITS (INDEXBITS)
  ) u_first (
    .i_frame      (w_first_mask),
    .i_index      ('0),
    .i_from_start (1'b1),
    .o_next       (w_first_idx),
    .o_found      (w_first_found)
  );

  // Next-state logic: IDLE -> BLANK -> DWELL -> BLANK ... ; run low parks in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_index_nxt  = r_led_index;
    w_enable_nxt = r_led_enable;
    w_done_nxt   = 1'b0;
    w_swap       = 1'b0;
    if (!run) begin
      w_state_nxt  = IDLE;
      w_index_nxt  = '0;
      w_enable_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_enable_nxt = 1'b0;
          if (r_shadow_full || r_have_frame) begin
            w_swap      = r_shadow_full;
            w_index_nxt = w_first_pos;
            w_cnt_nxt   = BLANK_LOAD;
            w_state_nxt = BLANK;
          end
        end
        BLANK: begin
          w_enable_nxt = 1'b0;
          if (r_cnt == '0) begin
            w_enable_nxt = r_active[r_led_index];
            w_cnt_nxt    = DWELL_LOAD;
            w_state_nxt  = DWELL;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        DWELL: begin
          if (r_cnt == '0) begin
            w_enable_nxt = 1'b0;
            w_cnt_nxt    = BLANK_LOAD;
            w_state_nxt  = BLANK;
            if (w_next_found) begin
              w_index_nxt = w_next_idx;
            end else begin
              // Scan wrap: report completion and pick up any waiting frame.
              w_done_nxt  = 1'b1;
              w_swap      = r_shadow_full;
              w_index_nxt = w_first_pos;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_index_nxt  = '0;
          w_enable_nxt = 1'b0;
        end
      endcase
    end
  end

  // Scan state, slot counter and registered charlieplexer outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_led_index  <= '0;
      r_led_enable <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_led_index  <= w_index_nxt;
      r_led_enable <= w_enable_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  // Shadow/active frame buffers and the frame handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active      <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_frame_ready <= 1'b1;
      r_have_frame  <= 1'b0;
    end else begin
      if (w_swap) begin
        r_active     <= r_shadow;
        r_have_frame <= 1'b1;
      end
      if (w_accept) begin
        r_shadow <= frame_data;
      end
      r_shadow_full <= w_shadow_full_nxt;
      r_frame_ready <= !w_shadow_full_nxt;
    end
  end

  assign frame_ready = r_frame_ready;
  assign led_index   = r_led_index;
  assign led_enable  = r_led_enable;
  assign frame_done  = r_frame_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Bench for charlieplex_scanner: 3 pins (6 LEDs), DWELL=4, BLANK=2.
// dut skips dark LEDs; dut0 gives every LED a slot.
module tb_charlieplex_scanner;
  import charlieplex_pkg::*;

  localparam int DWELL_CYC = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = DWELL_CYC + BLANK_CYC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        run, frame_valid, frame_ready, led_enable, frame_done;
  logic [5:0]  frame_data;
  logic [2:0]  led_index;
  scan_state_e dbg_state;

  logic        run0, frame_valid0, frame_ready0, led_enable0, frame_done0;
  logic [5:0]  frame_data0;
  logic [2:0]  led_index0;
  scan_state_e dbg_state0;

  charlieplex_scanner #(
    .PINCOUNT(3), .DWELL_CYCLES(DWELL_CYC), .BLANK_CYCLES(BLANK_CYC), .SKIP_DARK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .led_index(led_index),
    .led_enable(led_enable), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  charlieplex_scanner #(
    .PINCOUNT(3), .DWELL_CYCLES(DWELL_CYC), .BLANK_CYCLES(BLANK_CYC), .SKIP_DARK(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .frame_data(frame_data0),
    .frame_valid(frame_valid0), .frame_ready(frame_ready0), .led_index(led_index0),
    .led_enable(led_enable0), .frame_done(frame_done0), .dbg_state(dbg_state0)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // One entry per expected completed scan: {visited indices, lit indices}.
  logic [11:0] exp_q[$];
  logic [11:0] exp_q0[$];

  function automatic logic [11:0] exp_word(input bit skip, input logic [5:0] f);
    logic [5:0] visit;
    if (!skip)        visit = 6'h3F;
    else if (f == '0) visit = 6'd1;
    else              visit = f;
    return {visit, f};
  endfunction

  logic [5:0]  m_visit[2], m_lit[2];
  scan_state_e m_prev_st[2];
  logic        m_prev_en[2];
  logic [2:0]  m_prev_idx[2];
  int          m_run_len[2], m_en_len[2], m_cyc[2], m_last_done[2];
  bit          m_done_valid[2];

  task automatic monitor_step(input int id, input scan_state_e st, input logic [2:0] idx,
                              input logic en, input logic done, input logic rstn);
    logic [11:0] w;
    bit          have;
    m_cyc[id]++;
    if (!rstn) begin
      m_visit[id] = '0; m_lit[id] = '0; m_prev_st[id] = IDLE; m_prev_en[id] = 1'b0;
      m_prev_idx[id] = '0; m_run_len[id] = 0; m_en_len[id] = 0; m_done_valid[id] = 1'b0;
    end else begin
      if (en && m_prev_en[id]) check_eq("idx_stable_while_lit", idx, m_prev_idx[id]);
      if (st == DWELL) begin
        m_visit[id][idx] = 1'b1;
        if (en) m_lit[id][idx] = 1'b1;
      end
      if (st == m_prev_st[id]) m_run_len[id]++;
      else begin
        if (m_prev_st[id] == DWELL && st == BLANK) check_eq("dwell_len", m_run_len[id], DWELL_CYC);
        if (m_prev_st[id] == BLANK && st == DWELL) check_eq("blank_len", m_run_len[id], BLANK_CYC);
        m_run_len[id] = 1;
      end
      if (en) m_en_len[id]++;
      else begin
        if (m_prev_en[id] && st == BLANK) check_eq("enable_len", m_en_len[id], DWELL_CYC);
        m_en_len[id] = 0;
      end
      if (done) begin
        have = (id == 0) ? (exp_q0.size() != 0) : (exp_q.size() != 0);
        check_eq("scan_expected", have, 1);
        if (have) begin
          w = (id == 0) ? exp_q0.pop_front() : exp_q.pop_front();
          check_eq("scan_pattern", {m_visit[id], m_lit[id]}, w);
          if (m_done_valid[id])
            check_eq("scan_period", m_cyc[id] - m_last_done[id], $countones(w[11:6]) * SLOT);
        end
        m_visit[id] = '0; m_lit[id] = '0;
        m_last_done[id] = m_cyc[id]; m_done_valid[id] = 1'b1;
      end
      if (st == IDLE) begin
        m_visit[id] = '0; m_lit[id] = '0; m_done_valid[id] = 1'b0;
      end
      m_prev_st[id] = st; m_prev_en[id] = en; m_prev_idx[id] = idx;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_last_done[i] = 0; m_done_valid[i] = 1'b0;
      m_visit[i] = '0; m_lit[i] = '0; m_prev_st[i] = IDLE; m_prev_en[i] = 1'b0;
      m_prev_idx[i] = '0; m_run_len[i] = 0; m_en_len[i] = 0;
    end
  end

  always @(negedge clk) monitor_step(1, dbg_state, led_index, led_enable, frame_done, rst_n);
  always @(negedge clk) monitor_step(0, dbg_state0, led_index0, led_enable0, frame_done0, rst_n);

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic offer(input int id, input logic [5:0] d, input bit keep_valid);
    bit ok;
    bit rdy;
    ok = 1'b0;
    if (id == 0) begin frame_data0 = d; frame_valid0 = 1'b1; end
    else         begin frame_data  = d; frame_valid  = 1'b1; end
    for (int k = 0; k < 200 && !ok; k++) begin
      rdy = (id == 0) ? frame_ready0 : frame_ready;
      if (rdy) ok = 1'b1;
      @(negedge clk);
    end
    check_eq("frame_accepted", ok, 1);
    if (ok) check_eq("ready_drop_after_accept", (id == 0) ? frame_ready0 : frame_ready, 0);
    if (!keep_valid) begin
      if (id == 0) frame_valid0 = 1'b0; else frame_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int id, input int max_cyc);
    int sz;
    sz = (id == 0) ? exp_q0.size() : exp_q.size();
    for (int k = 0; k < max_cyc && sz != 0; k++) begin
      @(negedge clk);
      sz = (id == 0) ? exp_q0.size() : exp_q.size();
    end
    check_eq("scans_drained", sz, 0);
  endtask

  task automatic wait_done_ready(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        check_eq("ready_with_frame_done", frame_ready, 1);
      end
    end
    check_eq("frame_done_seen", seen, 1);
  endtask

  task automatic wait_lit_slot(input logic [2:0] idx, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge clk);
      if (dbg_state == DWELL && led_index == idx && led_enable) seen = 1'b1;
    end
    check_eq("lit_slot_reached", seen, 1);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [5:0] F_ALL = 6'b111111;
  localparam logic [5:0] F_25  = 6'b100100;
  localparam logic [5:0] F_A   = 6'b000011;
  localparam logic [5:0] F_B   = 6'b101010;
  localparam logic [5:0] F_C   = 6'b000000;
  localparam logic [5:0] F_5   = 6'b111010;

  initial begin
    bit en_seen;
    rst_n = 1'b0; run = 1'b0; run0 = 1'b0;
    frame_valid = 1'b0; frame_valid0 = 1'b0; frame_data = '0; frame_data0 = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_led_index", led_index, 0);
    check_eq("rst_led_enable", led_enable, 0);
    check_eq("rst_frame_ready", frame_ready, 1);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_frame_ready0", frame_ready0, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Every LED visited, enable only at indices 2 and 5
    run0 = 1'b1;
    repeat (2) exp_q0.push_back(exp_word(0, F_25));
    offer(0, F_25, 0);
    wait_drain(0, 200);
    run0 = 1'b0;

    // Full frame: 6 slots, 36-cycle scan
    run = 1'b1;
    repeat (3) exp_q.push_back(exp_word(1, F_ALL));
    offer(1, F_ALL, 0);
    wait_drain(1, 300);

    // New frame mid-scan: takes effect after the current scan, ready returns with frame_done
    exp_q.push_back(exp_word(1, F_ALL));
    repeat (2) exp_q.push_back(exp_word(1, F_25));
    offer(1, F_25, 0);
    wait_done_ready(100);
    wait_drain(1, 100);

    // Back-to-back A, B, C with valid held: order preserved, nothing lost or repeated
    exp_q.push_back(exp_word(1, F_25));
    exp_q.push_back(exp_word(1, F_A));
    exp_q.push_back(exp_word(1, F_B));
    repeat (2) exp_q.push_back(exp_word(1, F_C));
    offer(1, F_A, 1);
    offer(1, F_B, 1);
    offer(1, F_C, 0);
    wait_drain(1, 300);

    // run dropped during the DWELL of index 3
    exp_q.push_back(exp_word(1, F_C));
    offer(1, F_5, 0);
    wait_lit_slot(3'd3, 100);
    run = 1'b0;
    @(negedge clk);
    check_eq("stop_enable", led_enable, 0);
    check_eq("stop_index", led_index, 0);
    check_eq("stop_state", dbg_state, IDLE);
    check_eq("stop_done", frame_done, 0);
    repeat (8) @(negedge clk);
    check_eq("stop_no_scan", exp_q.size(), 0);

    // Re-raise run: restart at first lit LED (1) after two blank cycles
    exp_q.push_back(exp_word(1, F_5));
    run = 1'b1;
    @(negedge clk);
    check_eq("restart_blank1_en", led_enable, 0);
    check_eq("restart_blank1_idx", led_index, 1);
    @(negedge clk);
    check_eq("restart_blank2_en", led_enable, 0);
    @(negedge clk);
    check_eq("restart_lit_en", led_enable, 1);
    check_eq("restart_lit_idx", led_index, 1);
    wait_drain(1, 100);

    // Asynchronous reset mid-DWELL
    wait_lit_slot(3'd4, 100);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_enable", led_enable, 0);
    check_eq("arst_index", led_index, 0);
    check_eq("arst_ready", frame_ready, 1);
    check_eq("arst_done", frame_done, 0);
    check_eq("arst_state", dbg_state, IDLE);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    en_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      en_seen = en_seen | led_enable;
    end
    check_eq("no_enable_without_frame", en_seen, 0);
    check_eq("ready_after_reset", frame_ready, 1);

    // A fresh frame after reset scans again
    exp_q.push_back(exp_word(1, 6'b000001));
    offer(1, 6'b000001, 0);
    wait_drain(1, 100);
    run = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
